mod_n_updown_counter: RTL

MOD_N_UPDOWN_COUNTER -- requirements
Module: mod_n_updown_counter

---
 rtl/counter_pkg.sv | 12 +
 rtl/mod_n_tc_decode.sv | 25 ++
 rtl/mod_n_updown_counter.sv | 94 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared types and defaults for the mod-N up/down counter
package counter_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } count_dir_t;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 16;

endpackage

// File: rtl/mod_n_tc_decode.sv
// rtl/mod_n_tc_decode.sv - combinational terminal-count decode for the mod-N counter
module mod_n_tc_decode
    import counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic [WIDTH-1:0] Q,
    input  logic             up_dn,
    input  logic             enable,
    output logic             tc
);

    // Compared one bit wider so MODULUS == 2**WIDTH still decodes correctly
    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULUS - 1);

    logic at_top;
    logic at_bottom;

    assign at_top    = ({1'b0, Q} == LAST);
    assign at_bottom = (Q == '0);

    assign tc = enable & (((up_dn == DIR_UP) & at_top) | ((up_dn == DIR_DOWN) & at_bottom));

endmodule

// File: rtl/mod_n_updown_counter.sv
// rtl/mod_n_updown_counter.sv - mod-N up/down counter with wrap/saturate, sticky overflow; COUNTER_LOAD_EN adds parallel load
module mod_n_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int MODULUS  = DEFAULT_MODULUS,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_dn,
`ifdef COUNTER_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    input  logic             flag_clr,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH:0] LAST = (WIDTH + 1)'(MODULUS - 1);

    logic [WIDTH:0]   count_ext;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] load_clamped;
    logic             load_take;
    logic             ovf_set;
    logic             wrap_next;

    mod_n_tc_decode #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_decode (
        .Q      (Q),
        .up_dn  (up_dn),
        .enable (enable),
        .tc     (tc)
    );

    assign count_ext = {1'b0, Q};

`ifdef COUNTER_LOAD_EN
    assign load_take    = load;
    assign load_clamped = ({1'b0, load_val} > LAST) ? LAST[WIDTH-1:0] : load_val;
`else
    assign load_take    = 1'b0;
    assign load_clamped = '0;
`endif

    // A range-end edge (tc) either wraps or is a refused saturating step; load masks both
    assign ovf_set   = tc & ~load_take;
    assign wrap_next = ovf_set && (SATURATE == 0);

    always_comb begin
        q_next = Q;
        if (load_take) begin
            q_next = load_clamped;
        end else if (enable) begin
            if (up_dn == DIR_UP) begin
                if (count_ext == LAST) begin
                    q_next = (SATURATE != 0) ? LAST[WIDTH-1:0] : '0;
                end else begin
                    q_next = WIDTH'(count_ext + 1'b1);
                end
            end else begin
                if (count_ext == '0) begin
                    q_next = (SATURATE != 0) ? '0 : LAST[WIDTH-1:0];
                end else begin
                    q_next = WIDTH'(count_ext - 1'b1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            Q    <= '0;
            wrap <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            Q    <= q_next;
            wrap <= wrap_next;
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (flag_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule
